// File: rtl/x2050_ifetch_pkg.sv
// Shared types and constants for the x2050 instruction fetch unit.
// The FSM encoding and the length-to-byte scaling live here so the top and the adder agree.
package x2050_ifetch_pkg;

  localparam int ADDR_W_DEF = 24;
  localparam int LEN_W      = 2;   // instruction length field, in halfwords
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ERR  = 2'd2
  } state_e;

  // Halfword count to byte count: two bytes per halfword.
  function automatic logic [LEN_W:0] len_to_bytes(input logic [LEN_W-1:0] len);
    return {len, 1'b0};
  endfunction

endpackage

// File: rtl/x2050_iar_adder.sv
// IAR incrementer: adds 2*len bytes modulo 2^ADDR_W and flags a change of fullword.
module x2050_iar_adder
  import x2050_ifetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] iar_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic [ADDR_W-1:0] sum_o,
  output logic              word_cross_o
);

  logic [LEN_W:0] nbytes;

  assign nbytes       = len_to_bytes(len_i);
  assign sum_o        = iar_i + ADDR_W'(nbytes);
  assign word_cross_o = (sum_o[ADDR_W-1:2] != iar_i[ADDR_W-1:2]);

endmodule

// File: rtl/x2050_ifetch.sv
// Instruction fetch unit: holds the IAR, fetches the fullword under it into T,
// and tracks whether a halfword-aligned instruction spills into the next word.
module x2050_ifetch
  import x2050_ifetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_fetch,
  input  logic              i_iar_load,
  input  logic [ADDR_W-1:0] i_iar_in,
  input  logic              i_advance,
  input  logic [LEN_W-1:0]  i_len,
  input  logic [ADDR_W-1:0] i_mem_limit,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [31:0]       i_mem_data,
  output logic [ADDR_W-1:0] o_iar,
  output logic [31:0]       o_t_reg,
  output logic              o_ibfull,
  output logic              o_refetch,
  output logic              o_invalid_address,
  output logic              o_busy
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] iar_q, iar_d;
  logic [31:0]       t_reg_q, t_reg_d;
  logic              ibfull_q, ibfull_d;
  logic              refetch_q, refetch_d;
  logic              invalid_q, invalid_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic [ADDR_W-1:0] adv_sum;
  logic              adv_cross;
  logic              fetch_bad;
  logic [ADDR_W-1:0] word_addr;
  logic [ADDR_W-1:0] next_word_addr;

  x2050_iar_adder #(.ADDR_W(ADDR_W)) u_iar_adder (
    .iar_i        (iar_q),
    .len_i        (i_len),
    .sum_o        (adv_sum),
    .word_cross_o (adv_cross)
  );

  // The limit check is made on the halfword address, so limit-2 is the last legal IAR.
  assign fetch_bad      = iar_q[0] || (iar_q >= i_mem_limit);
  assign word_addr      = {iar_q[ADDR_W-1:2], 2'b00};
  assign next_word_addr = word_addr + ADDR_W'(WORD_BYTES);

  // NOTE: every variable gets its hold value first, so no path through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    iar_d      = iar_q;
    t_reg_d    = t_reg_q;
    ibfull_d   = ibfull_q;
    refetch_d  = refetch_q;
    invalid_d  = invalid_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;

    case (state_q)
      IDLE: begin
        if (i_iar_load) begin
          iar_d     = i_iar_in;
          ibfull_d  = 1'b0;
          refetch_d = 1'b0;
          invalid_d = 1'b0;
        end else if (i_fetch) begin
          if (fetch_bad) begin
            state_d   = ERR;
            invalid_d = 1'b1;
          end else begin
            state_d    = REQ;
            invalid_d  = 1'b0;
            mem_req_d  = 1'b1;
            mem_addr_d = refetch_q ? next_word_addr : word_addr;
          end
        end else if (i_advance) begin
          iar_d = adv_sum;
          if (adv_cross) begin
            ibfull_d  = 1'b0;
            refetch_d = 1'b0;
          end
        end
      end

      REQ: begin
        if (i_mem_ack) begin
          // refetch_q still marks whether this request was the second word of a spanning fetch.
          t_reg_d   = i_mem_data;
          ibfull_d  = 1'b1;
          refetch_d = iar_q[1] && !refetch_q;
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end

      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values; reset wins over any ack in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      iar_q      <= '0;
      t_reg_q    <= '0;
      ibfull_q   <= 1'b0;
      refetch_q  <= 1'b0;
      invalid_q  <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      iar_q      <= iar_d;
      t_reg_q    <= t_reg_d;
      ibfull_q   <= ibfull_d;
      refetch_q  <= refetch_d;
      invalid_q  <= invalid_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign o_iar             = iar_q;
  assign o_t_reg           = t_reg_q;
  assign o_ibfull          = ibfull_q;
  assign o_refetch         = refetch_q;
  assign o_invalid_address = invalid_q;
  assign o_mem_req         = mem_req_q;
  assign o_mem_addr        = mem_addr_q;
  assign o_busy            = (state_q != IDLE);

endmodule

// File: tb/tb_x2050_ifetch.sv
// Scoreboard bench for x2050_ifetch: stimulus queues expected request addresses and
// completions; a negedge monitor pops and compares them as the DUT presents them.
module tb_x2050_ifetch;

  logic        clk;
  logic        rst;
  logic        fetch;
  logic        iar_load;
  logic [23:0] iar_in;
  logic        advance;
  logic [1:0]  len;
  logic [23:0] mem_limit;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic [23:0] iar;
  logic [31:0] t_reg;
  logic        ibfull;
  logic        refetch;
  logic        invalid;
  logic        busy;

  typedef struct {
    logic [31:0] data;
    logic        refetch;
  } done_t;

  logic [23:0] exp_addr_q[$];
  done_t       exp_done_q[$];

  int checks = 0;
  int errors = 0;

  x2050_ifetch #(.ADDR_W(24)) dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .i_fetch           (fetch),
    .i_iar_load        (iar_load),
    .i_iar_in          (iar_in),
    .i_advance         (advance),
    .i_len             (len),
    .i_mem_limit       (mem_limit),
    .o_mem_req         (mem_req),
    .o_mem_addr        (mem_addr),
    .i_mem_ack         (mem_ack),
    .i_mem_data        (mem_data),
    .o_iar             (iar),
    .o_t_reg           (t_reg),
    .o_ibfull          (ibfull),
    .o_refetch         (refetch),
    .o_invalid_address (invalid),
    .o_busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_iar(input logic [23:0] v);
    iar_load = 1'b1;
    iar_in   = v;
    tick();
    iar_load = 1'b0;
  endtask

  // Valid fetch: the request address and completion are queued for the monitor.
  task automatic do_fetch(input logic [23:0] exp_addr, input logic [31:0] data,
                          input logic exp_rf, input int stall);
    done_t d;
    d.data    = data;
    d.refetch = exp_rf;
    exp_addr_q.push_back(exp_addr);
    exp_done_q.push_back(d);
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    repeat (stall) tick();
    mem_ack  = 1'b1;
    mem_data = data;
    tick();
    mem_ack  = 1'b0;
    mem_data = 32'hDEAD_BEEF;
  endtask

  task automatic advance_by(input logic [1:0] l);
    advance = 1'b1;
    len     = l;
    tick();
    advance = 1'b0;
  endtask

  // Monitor: checks each new request address, address stability, and each completion.
  logic        req_prev  = 1'b0;
  logic        done_pend = 1'b0;
  logic [23:0] addr_hold = '0;

  always @(negedge clk) begin
    done_t e;
    if (done_pend) begin
      if (exp_done_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: t_reg %h with no completion queued", t_reg);
      end else begin
        e = exp_done_q.pop_front();
        check("done_t_reg", t_reg, e.data);
        check("done_ibfull", 32'(ibfull), 32'd1);
        check("done_refetch", 32'(refetch), 32'(e.refetch));
        check("done_busy", 32'(busy), 32'd0);
      end
    end
    if (mem_req && !req_prev) begin
      if (exp_addr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_req: addr %h with no request queued", mem_addr);
      end else begin
        check("req_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
      end
      addr_hold <= mem_addr;
    end else if (mem_req && req_prev) begin
      check("req_addr_stable", 32'(mem_addr), 32'(addr_hold));
    end
    done_pend <= mem_req && mem_ack && !rst;
    req_prev  <= mem_req;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    fetch     = 1'b0;
    iar_load  = 1'b0;
    iar_in    = '0;
    advance   = 1'b0;
    len       = 2'd0;
    mem_limit = 24'hFFFFFF;
    mem_ack   = 1'b0;
    mem_data  = 32'hDEAD_BEEF;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    check("rst_iar", 32'(iar), 32'h0);
    check("rst_t_reg", t_reg, 32'h0);
    check("rst_flags", {28'h0, ibfull, refetch, invalid, busy}, 32'h0);
    check("rst_mem", {7'h0, mem_req, mem_addr}, 32'h0);

    // Scenario 1: aligned fetch, two-cycle latency to ibfull
    load_iar(24'h001000);
    check("s1_iar", 32'(iar), 32'h001000);
    exp_addr_q.push_back(24'h001000);
    exp_done_q.push_back('{data: 32'h12345678, refetch: 1'b0});
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    check("s1_busy_req", 32'(busy), 32'd1);
    check("s1_ibfull_c1", 32'(ibfull), 32'd0);
    mem_ack  = 1'b1;
    mem_data = 32'h12345678;
    tick();
    mem_ack  = 1'b0;
    mem_data = 32'hDEAD_BEEF;
    check("s1_ibfull_c2", 32'(ibfull), 32'd1);
    tick();
    check("s1_req_dropped", 32'(mem_req), 32'd0);

    // Scenario 2: halfword-offset instruction spans two words
    load_iar(24'h001002);
    check("s2_ibfull_cleared", 32'(ibfull), 32'd0);
    do_fetch(24'h001000, 32'hAAAA_0001, 1'b1, 1);
    tick();
    do_fetch(24'h001004, 32'hBBBB_0002, 1'b0, 0);
    tick();
    mem_ack  = 1'b1;
    mem_data = 32'h0BAD_F00D;
    tick();
    mem_ack  = 1'b0;
    check("s2_ack_in_idle_ignored", t_reg, 32'hBBBB_0002);

    // Scenario 3: limit boundary and odd address
    mem_limit = 24'h008000;
    load_iar(24'h007FFE);
    do_fetch(24'h007FFC, 32'hCCCC_0003, 1'b1, 0);
    tick();
    load_iar(24'h008000);
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    check("s3_limit_invalid", 32'(invalid), 32'd1);
    check("s3_err_busy", 32'(busy), 32'd1);
    tick();
    check("s3_err_one_cycle", 32'(busy), 32'd0);
    check("s3_invalid_held", 32'(invalid), 32'd1);
    load_iar(24'h000003);
    check("s3_load_clears_invalid", 32'(invalid), 32'd0);
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    check("s3_odd_invalid", 32'(invalid), 32'd1);
    tick();
    mem_limit = 24'hFFFFFF;

    // Scenario 4: advance wrap and in-word advance
    load_iar(24'hFFFFFC);
    do_fetch(24'hFFFFFC, 32'hDDDD_0004, 1'b0, 0);
    advance_by(2'd3);
    check("s4_wrap_iar", 32'(iar), 32'h000002);
    check("s4_wrap_ibfull", 32'(ibfull), 32'd0);
    load_iar(24'h001000);
    do_fetch(24'h001000, 32'hEEEE_0005, 1'b0, 0);
    advance_by(2'd1);
    check("s4_inword_iar", 32'(iar), 32'h001002);
    check("s4_inword_ibfull", 32'(ibfull), 32'd1);
    advance_by(2'd0);
    check("s4_len0_iar", 32'(iar), 32'h001002);
    advance_by(2'd1);
    check("s4_cross_iar", 32'(iar), 32'h001004);
    check("s4_cross_ibfull", 32'(ibfull), 32'd0);

    // Scenario 5: stalled ack with advance/load pulses that must be ignored
    load_iar(24'h002000);
    exp_addr_q.push_back(24'h002000);
    exp_done_q.push_back('{data: 32'h5555_AAAA, refetch: 1'b0});
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    for (int i = 0; i < 5; i++) begin
      advance  = (i % 2 == 0);
      len      = 2'd3;
      iar_load = (i % 2 == 1);
      iar_in   = 24'h005555;
      tick();
      check("s5_iar_held", 32'(iar), 32'h002000);
      check("s5_req_held", 32'(mem_req), 32'd1);
    end
    advance  = 1'b0;
    iar_load = 1'b0;
    mem_ack  = 1'b1;
    mem_data = 32'h5555_AAAA;
    tick();
    mem_ack  = 1'b0;
    check("s5_iar_after", 32'(iar), 32'h002000);
    tick();

    // Scenario 6: reset during REQ, then a late ack
    load_iar(24'h003000);
    exp_addr_q.push_back(24'h003000);
    fetch = 1'b1;
    tick();
    fetch = 1'b0;
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    mem_ack  = 1'b1;
    mem_data = 32'hCAFE_F00D;
    check("s6_req_dropped", 32'(mem_req), 32'd0);
    tick();
    mem_ack = 1'b0;
    check("s6_ibfull", 32'(ibfull), 32'd0);
    check("s6_t_reg", t_reg, 32'h0);
    check("s6_busy", 32'(busy), 32'd0);

    // Reset in IDLE with fetch and load asserted
    rst      = 1'b1;
    fetch    = 1'b1;
    iar_load = 1'b1;
    iar_in   = 24'h004000;
    tick();
    rst      = 1'b0;
    fetch    = 1'b0;
    iar_load = 1'b0;
    check("s6_idle_iar", 32'(iar), 32'h0);
    check("s6_idle_flags", {28'h0, ibfull, refetch, invalid, busy}, 32'h0);
    check("s6_idle_mem", {7'h0, mem_req, mem_addr}, 32'h0);
    tick();
    check("s6_idle_no_req", 32'(mem_req), 32'd0);

    repeat (3) tick();
    check("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
    check("done_queue_drained", 32'(exp_done_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
